cosine_controller: RTL and testbench
====================================

// Module: cosine_controller
// PURPOSE
//  Control FSM for the cosine/distance datapath: generates the 3-bit state code the datapath decodes.
//  Accepts a start request from the sensor front end and sequences Alert -> StartCalculation ->
//  AccumulateTerms (N_TERMS cycles) -> CalculateDistance.
//  Waits for the datapath done flag and presents the captured distance on a valid/ready result port.
//  Sits directly upstream of the datapath (drives its state input; consumes its done/distance outputs).
// PARAMETERS
//  N_TERMS      6    Taylor terms accumulated; AccumulateTerms dwell in cycles, legal range 1..15
//  WIDTH        16   distance width, must match datapath
//  DONE_TIMEOUT 8    max cycles spent in WaitDone before abort, legal range 1..255
// PORTS
//  clk             in   1      clock, rising edge
//  rst_n           in   1      asynchronous reset, active low
//  start_i         in   1      level request to begin a computation (sensor sample ready)
//  start_ack       out  1      1-cycle pulse: request accepted (high during Alert)
//  state           out  3      state code to datapath
//  term_idx        out  4      current term index during AccumulateTerms, 0 otherwise
//  busy            out  1      state != StandBy
//  dp_done         in   1      datapath done flag
//  dp_distance     in   WIDTH  datapath distance register
//  result_valid    out  1      result_distance holds an unconsumed result
//  result_ready    in   1      consumer accepts result when valid&ready
//  result_distance out  WIDTH  captured distance
//  timeout_err     out  1      1-cycle pulse: WaitDone expired without dp_done
// BEHAVIOUR
//  Reset (async, rst_n=0): state=StandBy, term_idx=0, counters=0, result_valid=0,
//    result_distance=0, start_ack=0, timeout_err=0. Reset mid-operation aborts immediately; no result.
//  Encoding: StandBy=0, Alert=1, StartCalculation=2, AccumulateTerms=3, CalculateDistance=4, WaitDone=5.
//    Codes 6,7 unreachable; if entered, next state is StandBy.
//  StandBy: -> Alert when start_i=1 AND result_valid=0 (backpressure: an unconsumed result blocks start).
//  Alert: 1 cycle, start_ack=1 -> StartCalculation.
//  StartCalculation: 1 cycle, term_cnt cleared -> AccumulateTerms.
//  AccumulateTerms: exactly N_TERMS cycles; term_idx = 0..N_TERMS-1; on the last cycle -> CalculateDistance.
//  CalculateDistance: 1 cycle -> WaitDone; wait counter cleared.
//  WaitDone: if dp_done=1, capture dp_distance into result_distance, set result_valid, -> StandBy.
//    Else count up; when the count reaches DONE_TIMEOUT, pulse timeout_err, -> StandBy, result_valid unchanged.
//  start_i is ignored while busy=1; it is not queued.
//  Result port: result_valid stays high and result_distance stable until a cycle with result_ready=1.
//    result_valid clears on the clock edge that ends that cycle.
//    result_ready while result_valid=0 has no effect.
//  Simultaneous: start_i=1 with a valid&ready handshake in the same StandBy cycle -> start not taken
//    (result_valid was 1 that cycle); it is taken on the next cycle if start_i is still high.
//  Latency: start sampled at edge k -> result_valid high from cycle k+N_TERMS+5, given datapath done
//    one cycle after CalculateDistance (N_TERMS=6 -> 11 cycles).
//  Throughput: one computation per N_TERMS+6 cycles with result_ready tied high.
//  All outputs registered except busy (decoded from the state register).
// STRUCTURE
//  cosine_pkg: state code localparams (ST_STANDBY..ST_WAIT_DONE), shared with the datapath decode.
//  Sub-module term_counter: 4-bit counter with clear/enable/terminal flag (N_TERMS-1).
//    Used for term_idx; a second instance with an 8-bit counter serves the WaitDone timeout.
//  Top: next-state logic, state register, result capture register, valid flag.
// TESTING
//  1 Basic: start_i pulse 1 cycle, dp_done model 1 cycle after state=4, dp_distance=16'h1A2B, ready=1
//    -> states 1,2,3x6,4,5,0; result_valid 1 cycle at k+11 with 16'h1A2B.
//  2 Backpressure: ready=0 after result, start_i held high -> stays StandBy, busy=0;
//    ready=1 for 1 cycle -> valid drops; next cycle -> Alert.
//  3 Start while busy: extra start_i pulses during AccumulateTerms -> exactly one start_ack, one result.
//  4 Timeout: dp_done held 0 -> 8 cycles in state 5, timeout_err 1-cycle pulse, back to 0, result_valid=0.
//  5 Reset mid-op: rst_n low during AccumulateTerms (term_idx=3) -> state=0, term_idx=0 immediately;
//    no result_valid after release.
//  6 Boundary N_TERMS=1: one AccumulateTerms cycle, term_idx=0, result at k+6; back-to-back starts
//    with ready=1 -> one result every 7 cycles.

Source files
------------

// File: rtl/cosine_pkg.sv
// Shared definitions for the cosine/distance controller and its datapath.
// The state codes are the 3-bit values the datapath decodes directly.
package cosine_pkg;

  typedef enum logic [2:0] {
    ST_STANDBY    = 3'd0,
    ST_ALERT      = 3'd1,
    ST_START_CALC = 3'd2,
    ST_ACCUMULATE = 3'd3,
    ST_CALC_DIST  = 3'd4,
    ST_WAIT_DONE  = 3'd5
  } state_e;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned TERM_IDX_W = 4;
  localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/term_counter.sv
// Up-counter with synchronous clear, count enable and a terminal flag.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   clr         synchronous clear, has priority over en
//   en          increment by one
//   count       current count value
//   terminal    high while count == LAST
module term_counter #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned LAST  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == LAST_V);

endmodule

// File: rtl/cosine_controller.sv
// Control FSM for the cosine/distance datapath. Accepts a start request,
// sequences Alert -> StartCalculation -> AccumulateTerms (N_TERMS cycles)
// -> CalculateDistance -> WaitDone, then captures the datapath distance and
// offers it on a valid/ready result port. WaitDone aborts after DONE_TIMEOUT
// cycles without dp_done.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start_i          level start request, honoured only in StandBy with no pending result
//   start_ack        1-cycle pulse, high during Alert
//   state            3-bit state code to the datapath
//   term_idx         term index during AccumulateTerms, 0 otherwise
//   busy             state != StandBy (decoded, not registered)
//   dp_done          datapath done flag
//   dp_distance      datapath distance value
//   result_valid     result_distance holds an unconsumed result
//   result_ready     consumer accepts when result_valid & result_ready
//   result_distance  captured distance
//   timeout_err      1-cycle pulse after WaitDone expires without dp_done
module cosine_controller
  import cosine_pkg::*;
#(
  parameter int unsigned N_TERMS      = 6,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DONE_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  start_ack,
  output logic [STATE_W-1:0]    state,
  output logic [TERM_IDX_W-1:0] term_idx,
  output logic                  busy,
  input  logic                  dp_done,
  input  logic [WIDTH-1:0]      dp_distance,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [WIDTH-1:0]      result_distance,
  output logic                  timeout_err
);

  state_e state_q;
  state_e state_d;

  logic                  term_last;
  logic                  wait_last;
  logic [WAIT_CNT_W-1:0] wait_cnt_unused;

  logic ack_d;
  logic timeout_d;
  logic capture;

  // The term counter is held at zero outside AccumulateTerms and wraps back
  // to zero on the last term, so its count doubles as the term_idx output.
  term_counter #(
    .CNT_W (TERM_IDX_W),
    .LAST  (N_TERMS - 1)
  ) u_term_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      ((state_q != ST_ACCUMULATE) || term_last),
    .en       (state_q == ST_ACCUMULATE),
    .count    (term_idx),
    .terminal (term_last)
  );

  // Counts WaitDone cycles from zero; terminal marks the last allowed cycle.
  term_counter #(
    .CNT_W (WAIT_CNT_W),
    .LAST  (DONE_TIMEOUT - 1)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q != ST_WAIT_DONE),
    .en       (1'b1),
    .count    (wait_cnt_unused),
    .terminal (wait_last)
  );

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    timeout_d = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_STANDBY: begin
        // A pending result blocks the start, even if it is consumed this cycle.
        if (start_i && !result_valid) begin
          state_d = ST_ALERT;
          ack_d   = 1'b1;
        end
      end
      ST_ALERT:      state_d = ST_START_CALC;
      ST_START_CALC: state_d = ST_ACCUMULATE;
      ST_ACCUMULATE: begin
        if (term_last) begin
          state_d = ST_CALC_DIST;
        end
      end
      ST_CALC_DIST:  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        // dp_done on the final allowed cycle still wins over the timeout.
        if (dp_done) begin
          capture = 1'b1;
          state_d = ST_STANDBY;
        end else if (wait_last) begin
          timeout_d = 1'b1;
          state_d   = ST_STANDBY;
        end
      end
      default:       state_d = ST_STANDBY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_STANDBY;
      start_ack       <= 1'b0;
      timeout_err     <= 1'b0;
      result_valid    <= 1'b0;
      result_distance <= '0;
    end else begin
      state_q     <= state_d;
      start_ack   <= ack_d;
      timeout_err <= timeout_d;
      if (capture) begin
        result_valid    <= 1'b1;
        result_distance <= dp_distance;
      end else if (result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

  assign state = state_q;
  assign busy  = (state_q != ST_STANDBY);

endmodule

// File: tb/tb_cosine_controller.sv
module tb_cosine_controller;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        result_ready;
  logic        dp_en;
  logic [15:0] dp_distance;

  logic        ack0, busy0, rv0, to0, done0;
  logic [2:0]  st0;
  logic [3:0]  ti0;
  logic [15:0] rd0;
  logic        ack1, busy1, rv1, to1, done1;
  logic [2:0]  st1;
  logic [3:0]  ti1;
  logic [15:0] rd1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cosine_controller #(.N_TERMS(6), .WIDTH(16), .DONE_TIMEOUT(TMO)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .start_ack(ack0), .state(st0),
    .term_idx(ti0), .busy(busy0), .dp_done(done0), .dp_distance(dp_distance),
    .result_valid(rv0), .result_ready(result_ready), .result_distance(rd0),
    .timeout_err(to0));

  cosine_controller #(.N_TERMS(1), .WIDTH(16), .DONE_TIMEOUT(TMO)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .start_ack(ack1), .state(st1),
    .term_idx(ti1), .busy(busy1), .dp_done(done1), .dp_distance(dp_distance),
    .result_valid(rv1), .result_ready(result_ready), .result_distance(rd1),
    .timeout_err(to1));

  // Datapath stand-ins: done one cycle after CalculateDistance, unless disabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) done0 <= 1'b0;
    else        done0 <= dp_en && (st0 == 3'd4);
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) done1 <= 1'b0;
    else        done1 <= dp_en && (st1 == 3'd4);
  end

  // Reference model: a timeline position per instance. 0 = idle, 1 = Alert,
  // 2 = StartCalculation, 3..n+2 = terms, n+3 = CalculateDistance, then waiting.
  int          m_phase [2];
  bit          m_valid [2];
  bit          m_to    [2];
  logic [15:0] m_dist  [2];

  int acks [2];
  int tos  [2];
  int w5   [2];
  int hs   [2];
  int cyc_no = 0;

  function automatic int nterms(input int i);
    return (i == 0) ? 6 : 1;
  endfunction

  function automatic logic [31:0] exp_state(input int ph, input int n);
    if (ph == 0)     return 0;
    if (ph == 1)     return 1;
    if (ph == 2)     return 2;
    if (ph <= n + 2) return 3;
    if (ph == n + 3) return 4;
    return 5;
  endfunction

  function automatic logic [31:0] exp_idx(input int ph, input int n);
    if (ph >= 3 && ph <= n + 2) return ph - 3;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0;
      m_valid[i] = 1'b0;
      m_to[i]    = 1'b0;
      m_dist[i]  = 16'h0;
    end
  endtask

  task automatic model_step(input int i, input logic d);
    int n;
    bit v_old;
    n     = nterms(i);
    v_old = m_valid[i];
    m_to[i] = 1'b0;
    if (m_valid[i] && result_ready) m_valid[i] = 1'b0;
    if (m_phase[i] == 0) begin
      if (start_i && !v_old) m_phase[i] = 1;
    end else if (m_phase[i] < n + 4) begin
      m_phase[i]++;
    end else if (d) begin
      m_dist[i]  = dp_distance;
      m_valid[i] = 1'b1;
      m_phase[i] = 0;
    end else if (m_phase[i] - (n + 4) == TMO - 1) begin
      m_to[i]    = 1'b1;
      m_phase[i] = 0;
    end else begin
      m_phase[i]++;
    end
  endtask

  task automatic check_inst(input int i, input logic [2:0] s, input logic [3:0] ti,
                            input logic b, input logic a, input logic v,
                            input logic [15:0] rd, input logic to);
    int n;
    n = nterms(i);
    chk($sformatf("i%0d_state@%0d", i, cyc_no), s, exp_state(m_phase[i], n));
    chk($sformatf("i%0d_term_idx@%0d", i, cyc_no), ti, exp_idx(m_phase[i], n));
    chk($sformatf("i%0d_busy@%0d", i, cyc_no), b, m_phase[i] != 0);
    chk($sformatf("i%0d_start_ack@%0d", i, cyc_no), a, m_phase[i] == 1);
    chk($sformatf("i%0d_result_valid@%0d", i, cyc_no), v, m_valid[i]);
    chk($sformatf("i%0d_result_distance@%0d", i, cyc_no), rd, m_dist[i]);
    chk($sformatf("i%0d_timeout_err@%0d", i, cyc_no), to, m_to[i]);
  endtask

  task automatic check_all();
    check_inst(0, st0, ti0, busy0, ack0, rv0, rd0, to0);
    check_inst(1, st1, ti1, busy1, ack1, rv1, rd1, to1);
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rv0 && result_ready) hs[0]++;
    if (rv1 && result_ready) hs[1]++;
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, done0);
      model_step(1, done1);
    end
    @(negedge clk);
    cyc_no++;
    if (ack0) acks[0]++;
    if (ack1) acks[1]++;
    if (to0) tos[0]++;
    if (to1) tos[1]++;
    if (st0 == 3'd5) w5[0]++;
    if (st1 == 3'd5) w5[1]++;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, f1, a0, h0, t0, t1, w0, w1, k;
    int q0[$];
    int q1[$];

    for (int i = 0; i < 2; i++) begin
      acks[i] = 0; tos[i] = 0; w5[i] = 0; hs[i] = 0;
    end
    model_reset();
    start_i = 1'b0; result_ready = 1'b1; dp_en = 1'b1; dp_distance = 16'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // 1: basic sequence and latency
    dp_distance = 16'h1A2B;
    start_i = 1'b1;
    f0 = 0; f1 = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (c == 1) start_i = 1'b0;
      if (rv0 && f0 == 0) f0 = c;
      if (rv1 && f1 == 0) f1 = c;
    end
    chk("latency_n6", f0, 11);
    chk("latency_n1", f1, 6);
    chk("basic_distance", rd0, 16'h1A2B);

    // 2: backpressure with start held high
    result_ready = 1'b0;
    dp_distance = 16'h00C3;
    start_i = 1'b1;
    for (int c = 0; c < 16; c++) cyc();
    chk("bp_busy0", busy0, 1'b0);
    chk("bp_valid0", rv0, 1'b1);
    chk("bp_state1", st1, 3'd0);
    result_ready = 1'b1;
    cyc();
    chk("bp_valid_drop", rv0, 1'b0);
    chk("bp_still_standby", st0, 3'd0);
    cyc();
    chk("bp_then_alert", st0, 3'd1);
    start_i = 1'b0;
    for (int c = 0; c < 14; c++) cyc();

    // 3: start pulses while busy are ignored
    a0 = acks[0]; h0 = hs[0];
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    for (int c = 0; c < 3; c++) cyc();
    start_i = 1'b1;
    for (int c = 0; c < 3; c++) cyc();
    start_i = 1'b0;
    for (int c = 0; c < 20; c++) cyc();
    chk("busy_start_acks", acks[0] - a0, 1);
    chk("busy_start_results", hs[0] - h0, 1);

    // 4: timeout
    dp_en = 1'b0;
    t0 = tos[0]; t1 = tos[1]; w0 = w5[0]; w1 = w5[1];
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    for (int c = 0; c < 25; c++) cyc();
    chk("tmo_wait_cycles0", w5[0] - w0, TMO);
    chk("tmo_wait_cycles1", w5[1] - w1, TMO);
    chk("tmo_pulses0", tos[0] - t0, 1);
    chk("tmo_pulses1", tos[1] - t1, 1);
    chk("tmo_valid0", rv0, 1'b0);
    dp_en = 1'b1;

    // 5: reset in the middle of AccumulateTerms
    h0 = hs[0];
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    k = 0;
    while (ti0 != 4'd3 && k < 12) begin
      cyc();
      k++;
    end
    chk("rst_reached_idx3", ti0, 4'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state_now", st0, 3'd0);
    chk("rst_term_idx_now", ti0, 4'd0);
    chk("rst_busy_now", busy0, 1'b0);
    model_reset();
    check_all();
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) cyc();
    chk("rst_no_result", hs[0] - h0, 0);

    // 6: back-to-back throughput
    result_ready = 1'b1;
    start_i = 1'b1;
    for (int c = 0; c < 60; c++) begin
      cyc();
      if (rv0) q0.push_back(cyc_no);
      if (rv1) q1.push_back(cyc_no);
    end
    start_i = 1'b0;
    chk("tp_count1_enough", q1.size() >= 5, 1);
    chk("tp_count0_enough", q0.size() >= 3, 1);
    for (int j = 1; j < 5 && j < q1.size(); j++) chk("tp_period_n1", q1[j] - q1[j-1], 7);
    for (int j = 1; j < 3 && j < q0.size(); j++) chk("tp_period_n6", q0[j] - q0[j-1], 12);
    for (int c = 0; c < 20; c++) cyc();

    // Randomized traffic checked against the model every cycle
    for (int c = 0; c < 1500; c++) begin
      start_i      = ($urandom_range(0, 3) == 0);
      result_ready = ($urandom_range(0, 1) == 1);
      dp_en        = ($urandom_range(0, 7) != 0);
      dp_distance  = 16'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
